rcdbpot_pipe: RTL

- Pipelined, multi-lane successor to the single-lane combinational rounding/clamping divide-by-power-of-two.
- Each lane does four things:
  - takes a DATA_W-bit signed accumulator;
  - divides it by 2^shift, rounding half away from zero;
  - adds a signed output offset;
  - clamps the sum to a runtime [act_min, act_max] window.
- Sits between the MAC accumulator bank and the int8 output packer in the CFU datapath. Uses valid/ready handshaking and keeps a saturation event counter for debug and profiling.

---
 rtl/rcdbpot_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rcdbpot_pipe.sv
// Multi-lane divide-by-2^shift with round-half-away-from-zero, signed offset and
// runtime clamp; two register stages with valid/ready flow control and a sticky saturation counter.
module rcdbpot_pipe #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned SHIFT_W = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [SHIFT_W-1:0]        in_shift,
    input  logic [DATA_W-1:0]         in_offset,
    input  logic [OUT_W-1:0]          in_act_min,
    input  logic [OUT_W-1:0]          in_act_max,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OUT_W-1:0]    out_data,
    output logic [CNT_W-1:0]          sat_count,
    input  logic                      sat_clear
);

    localparam int unsigned VW = DATA_W + 2;

    logic                     w_en;
    logic signed [DATA_W-1:0] w_div [LANES];
    logic signed [DATA_W-1:0] w_q   [LANES];
    logic [LANES-1:0]         w_rnd;
    logic [DATA_W-1:0]        w_mask;
    logic [DATA_W-1:0]        w_half;

    logic                     r_s1_valid;
    logic signed [DATA_W-1:0] r_s1_q [LANES];
    logic [LANES-1:0]         r_s1_rnd;
    logic [DATA_W-1:0]        r_s1_off;
    logic [OUT_W-1:0]         r_s1_min;
    logic [OUT_W-1:0]         r_s1_max;

    logic signed [VW-1:0]     w_v [LANES];
    logic signed [VW-1:0]     w_lo;
    logic signed [VW-1:0]     w_hi;
    logic [LANES-1:0]         w_sat;
    logic [LANES*OUT_W-1:0]   w_res;
    logic [CNT_W:0]           w_nsat;
    logic [CNT_W:0]           w_sum;
    logic [CNT_W-1:0]         w_cnt_next;

    logic                     r_s2_valid;
    logic [LANES*OUT_W-1:0]   r_out_data;
    logic [CNT_W-1:0]         r_sat_count;

    assign w_en      = !r_s2_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign sat_count = r_sat_count;

    // Round up when the discarded fraction exceeds one half; negative ties need one more to fall to floor.
    always_comb begin
        w_div  = '{default: '0};
        w_q    = '{default: '0};
        w_rnd  = '0;
        w_mask = ~({DATA_W{1'b1}} << in_shift);
        w_half = w_mask >> 1;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_div[i] = in_data[i*DATA_W +: DATA_W];
            w_q[i]   = w_div[i] >>> in_shift;
            w_rnd[i] = ($unsigned(w_div[i]) & w_mask) >
                       (w_half + {{(DATA_W-1){1'b0}}, w_div[i][DATA_W-1]});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_q     <= '{default: '0};
            r_s1_rnd   <= '0;
            r_s1_off   <= '0;
            r_s1_min   <= '0;
            r_s1_max   <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_q     <= w_q;
            r_s1_rnd   <= w_rnd;
            r_s1_off   <= in_offset;
            r_s1_min   <= in_act_min;
            r_s1_max   <= in_act_max;
        end
    end

    always_comb begin
        w_v    = '{default: '0};
        w_sat  = '0;
        w_res  = '0;
        w_nsat = '0;
        w_lo   = {{(VW-OUT_W){r_s1_min[OUT_W-1]}}, r_s1_min};
        w_hi   = {{(VW-OUT_W){r_s1_max[OUT_W-1]}}, r_s1_max};
        for (int unsigned i = 0; i < LANES; i++) begin
            w_v[i] = {{2{r_s1_q[i][DATA_W-1]}}, r_s1_q[i]}
                   + {{(VW-1){1'b0}}, r_s1_rnd[i]}
                   + {{2{r_s1_off[DATA_W-1]}}, r_s1_off};
            if (w_v[i] < w_lo) begin
                w_sat[i]                  = 1'b1;
                w_res[i*OUT_W +: OUT_W]   = w_lo[OUT_W-1:0];
            end else if (w_v[i] > w_hi) begin
                w_sat[i]                  = 1'b1;
                w_res[i*OUT_W +: OUT_W]   = w_hi[OUT_W-1:0];
            end else begin
                w_res[i*OUT_W +: OUT_W]   = w_v[i][OUT_W-1:0];
            end
            w_nsat = w_nsat + {{CNT_W{1'b0}}, w_sat[i]};
        end
        w_sum      = {1'b0, r_sat_count} + w_nsat;
        w_cnt_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_res;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sat_count <= '0;
        end else if (sat_clear) begin
            r_sat_count <= '0;
        end else if (w_en && r_s1_valid) begin
            r_sat_count <= w_cnt_next;
        end
    end

endmodule
